// File: rtl/fifo_pkg.sv
// Types and pointer-compare helpers shared by the FIFO controller and its pointer registers.
package fifo_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_NORMAL = 2'd1,
        ST_FULL   = 2'd2
    } fifo_state_e;

    // Pointers carry one wrap bit above the address bits.
    // Full means the addresses match and only the wrap bit differs.
    function automatic logic ptrs_full(input logic [31:0] wr, input logic [31:0] rd,
                                       input int addr_w);
        return (wr ^ rd) == (32'd1 << addr_w);
    endfunction

    function automatic logic ptrs_empty(input logic [31:0] wr, input logic [31:0] rd);
        return wr == rd;
    endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register: address bits plus a wrap bit, counts modulo 2*DEPTH.
module fifo_ptr #(
    parameter int PTR_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [PTR_W-1:0] o_ptr
);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (!rst_n || i_clr) begin
            r_ptr <= '0;
        end else if (i_inc) begin
            r_ptr <= r_ptr + PTR_W'(1);
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/fifo_ctrl_dp.sv
// FIFO controller for an external dual-port RAM (sync write, async read) with a
// valid/ready input stream and a first-word-fall-through output stream.
module fifo_ctrl_dp
    import fifo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 16,
    parameter int DEPTH_LOG = $clog2(DEPTH),
    parameter int AF_LEVEL  = DEPTH - 2,
    parameter int AE_LEVEL  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic                 ram_we,
    output logic [DEPTH_LOG-1:0] ram_addr_wr,
    output logic [DEPTH_LOG-1:0] ram_addr_rd,
    output logic [WIDTH-1:0]     ram_data_wr,
    input  logic [WIDTH-1:0]     ram_data_rd,
    output logic [DEPTH_LOG:0]   count,
    output logic                 almost_full,
    output logic                 almost_empty
);

    localparam int            CW       = DEPTH_LOG + 1;
    localparam logic [CW-1:0] AF_L     = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_L     = CW'(AE_LEVEL);
    localparam logic [CW-1:0] DEPTH_M1 = CW'(DEPTH - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    fifo_state_e   r_state, w_state_nxt;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_wr_ptr, w_rd_ptr;
    logic          w_in_ready, w_out_valid, w_push, w_pop;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_in_ready = !flush;
                if (in_valid) w_state_nxt = ST_NORMAL;
            end
            ST_NORMAL: begin
                w_in_ready  = !flush;
                w_out_valid = !flush;
                if (in_valid && !out_ready && r_count == DEPTH_M1) w_state_nxt = ST_FULL;
                else if (out_ready && !in_valid && r_count == ONE) w_state_nxt = ST_EMPTY;
            end
            ST_FULL: begin
                w_out_valid = !flush;
                if (out_ready) w_state_nxt = ST_NORMAL;
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
        if (flush) w_state_nxt = ST_EMPTY;
    end

    // in_ready stays visible during reset, but no handshake may land while rst_n is low.
    assign w_push = rst_n & in_valid & w_in_ready;
    assign w_pop  = rst_n & out_ready & w_out_valid;

    fifo_ptr #(.PTR_W(CW)) u_wr_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_push),
        .o_ptr (w_wr_ptr)
    );

    fifo_ptr #(.PTR_W(CW)) u_rd_ptr (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (flush),
        .i_inc (w_pop),
        .o_ptr (w_rd_ptr)
    );

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_count <= '0;
        end else if (w_push && !w_pop) begin
            r_count <= r_count + ONE;
        end else if (w_pop && !w_push) begin
            r_count <= r_count - ONE;
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_data     = ram_data_rd;
    assign ram_we       = w_push;
    assign ram_addr_wr  = w_wr_ptr[DEPTH_LOG-1:0];
    assign ram_addr_rd  = w_rd_ptr[DEPTH_LOG-1:0];
    assign ram_data_wr  = in_data;
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_L);
    assign almost_empty = (r_count <= AE_L);

    a_count_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        r_count == CW'(w_wr_ptr - w_rd_ptr));
    a_full_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_FULL) == ptrs_full(32'(w_wr_ptr), 32'(w_rd_ptr), DEPTH_LOG));
    a_empty_ptrs: assert property (@(posedge clk) disable iff (!rst_n)
        (r_state == ST_EMPTY) == ptrs_empty(32'(w_wr_ptr), 32'(w_rd_ptr)));
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_push && r_state == ST_FULL));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(w_pop && r_state == ST_EMPTY));

endmodule

// File: tb/tb_fifo_ctrl_dp.sv
// Directed bench for fifo_ctrl_dp with a behavioural RAM and a data scoreboard.
module tb_fifo_ctrl_dp;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst_n, flush, in_valid, in_ready, out_valid, out_ready, ram_we;
    logic       almost_full, almost_empty;
    logic [7:0] in_data, out_data, ram_data_wr, ram_data_rd;
    logic [3:0] ram_addr_wr, ram_addr_rd;
    logic [4:0] count;
    logic [7:0] mem [D];

    int         checks    = 0;
    int         failures  = 0;
    int         exp_count = 0;
    int         exp_wr    = 0;
    int         exp_rd    = 0;
    logic [7:0] sb [$];

    always #5 clk = ~clk;

    always @(posedge clk) if (ram_we) mem[ram_addr_wr] <= ram_data_wr;
    assign ram_data_rd = mem[ram_addr_rd];

    fifo_ctrl_dp #(.WIDTH(8), .DEPTH(D)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .ram_we       (ram_we),
        .ram_addr_wr  (ram_addr_wr),
        .ram_addr_rd  (ram_addr_rd),
        .ram_data_wr  (ram_data_wr),
        .ram_data_rd  (ram_data_rd),
        .count        (count),
        .almost_full  (almost_full),
        .almost_empty (almost_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check combinational outputs against the model,
    // step the edge, then check the registered occupancy and flags.
    task automatic cycle(input logic v, input logic [7:0] d, input logic r, input logic f);
        logic e_ir, e_ov, e_push, e_pop;
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
        e_ir   = !f && (exp_count != D);
        e_ov   = !f && (exp_count != 0);
        e_push = v && e_ir;
        e_pop  = r && e_ov;
        chk("in_ready", 32'(in_ready), 32'(e_ir));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("ram_we", 32'(ram_we), 32'(e_push));
        if (e_push) begin
            chk("addr_wr", 32'(ram_addr_wr), 32'(exp_wr));
            chk("data_wr", 32'(ram_data_wr), 32'(d));
        end
        if (e_ov) chk("addr_rd", 32'(ram_addr_rd), 32'(exp_rd));
        if (e_pop) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $error("FAIL sb_underflow: observed=%0h expected=none", out_data);
            end else begin
                chk("out_data", 32'(out_data), 32'(sb.pop_front()));
            end
        end
        if (e_push) sb.push_back(d);
        @(posedge clk);
        #1;
        if (f) begin
            exp_count = 0;
            exp_wr    = 0;
            exp_rd    = 0;
            sb.delete();
        end else begin
            exp_count = exp_count + (e_push ? 1 : 0) - (e_pop ? 1 : 0);
            if (e_push) exp_wr = (exp_wr + 1) % D;
            if (e_pop)  exp_rd = (exp_rd + 1) % D;
        end
        chk("count", 32'(count), 32'(exp_count));
        chk("almost_full", 32'(almost_full), 32'(exp_count >= D - 2));
        chk("almost_empty", 32'(almost_empty), 32'(exp_count <= 2));
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < D; i++) mem[i] = 8'h00;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h77;
        out_ready = 1'b0;

        // Reset held two cycles with in_valid asserted
        @(posedge clk);
        #1;
        chk("rst_ram_we", 32'(ram_we), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_almost_empty", 32'(almost_empty), 32'd1);
        chk("rst_almost_full", 32'(almost_full), 32'd0);
        @(posedge clk);
        #1;
        chk("rst2_ram_we", 32'(ram_we), 32'd0);
        @(negedge clk);
        rst_n    = 1'b1;
        in_valid = 1'b0;

        // Fill to full, then hold a 17th word while the consumer stalls
        for (int i = 0; i < D; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0);
        repeat (3) cycle(1'b1, 8'h10, 1'b0, 1'b0);

        // Drain in order
        repeat (D) cycle(1'b0, 8'h00, 1'b1, 1'b0);

        // Concurrent push/pop at count 8 long enough to wrap both pointers
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(32'h20 + i), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'(32'h40 + i), 1'b1, 1'b0);

        // Full with out_ready: pop only, then push and pop together
        for (int i = 0; i < 8; i++) cycle(1'b1, 8'(32'h80 + i), 1'b0, 1'b0);
        cycle(1'b1, 8'h90, 1'b1, 1'b0);
        cycle(1'b1, 8'h91, 1'b1, 1'b0);

        // Down to 5, flush with a push pending, then a fresh word
        repeat (10) cycle(1'b0, 8'h00, 1'b1, 1'b0);
        cycle(1'b1, 8'hFF, 1'b0, 1'b1);
        cycle(1'b1, 8'hA5, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
